// File: rtl/scaled_addr_gen_if.sv
// Handshake bundle between the scale-parameter stage, the address generator and the resize stage.
// Carries the parameter handshake inputs and the address-stream outputs with their status flags.
// The master drives parameters and addr_ready. The slave drives param_ready, the address beat and status.
interface scaled_addr_gen_if #(
    parameter int COORD_BITS = 10,
    parameter int FRAC_BITS  = 16,
    parameter int ADDR_BITS  = 17
);
    logic                            param_valid;
    logic                            param_ready;
    logic [COORD_BITS+FRAC_BITS-1:0] inv_scale;
    logic [COORD_BITS-1:0]           new_width;
    logic [COORD_BITS-1:0]           new_height;
    logic                            addr_valid;
    logic                            addr_ready;
    logic [ADDR_BITS-1:0]            src_addr;
    logic [COORD_BITS-1:0]           dst_x;
    logic [COORD_BITS-1:0]           dst_y;
    logic                            last_pixel;
    logic                            busy;
    logic                            done;

    modport master (
        output param_valid, inv_scale, new_width, new_height, addr_ready,
        input  param_ready, addr_valid, src_addr, dst_x, dst_y, last_pixel, busy, done
    );

    modport slave (
        input  param_valid, inv_scale, new_width, new_height, addr_ready,
        output param_ready, addr_valid, src_addr, dst_x, dst_y, last_pixel, busy, done
    );
endinterface

// File: rtl/scaled_addr_gen.sv
// Nearest-neighbour source address generator: raster-walks a scaled image and emits frame-buffer addresses.
// Latency: accept at T gives the first addr_valid at T+3, one bubble per row, and done one cycle after the final beat.
// Backpressure: the beat is held stable while addr_valid && !addr_ready. Parameters are accepted only while idle.
// Ports: clk, reset (sync, active-high), bus (scaled_addr_gen_if.slave: parameter handshake in, address stream out).
// Build option SCALE_CENTER_SAMPLE_EN: when defined, accumulators start at inv_scale/2 (pixel-centre sampling).
module scaled_addr_gen #(
    parameter int SRC_WIDTH  = 320,
    parameter int SRC_HEIGHT = 240,
    parameter int COORD_BITS = 10,
    parameter int FRAC_BITS  = 16,
    parameter int ADDR_BITS  = 17
) (
    input  logic              clk,
    input  logic              reset,
    scaled_addr_gen_if.slave  bus
);
    localparam int IW = COORD_BITS + FRAC_BITS;
    localparam int AW = COORD_BITS + FRAC_BITS + 1;
    localparam logic [IW-1:0] ONE_I = IW'(1 << FRAC_BITS);

    typedef enum logic [2:0] {S_Idle, S_Load, S_RowCalc, S_Emit, S_Done} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         inv_q, inv_d;
    logic [COORD_BITS-1:0] width_q, width_d, height_q, height_d;
    logic [COORD_BITS-1:0] dst_x_q, dst_x_d, dst_y_q, dst_y_d;
    logic [AW-1:0]         x_acc_q, x_acc_d, y_acc_q, y_acc_d;
    logic [ADDR_BITS-1:0]  row_base_q, row_base_d, src_addr_q, src_addr_d;
    logic                  addr_valid_q, addr_valid_d, last_q, last_d;
    logic                  busy_q, busy_d, done_q, done_d, param_ready_q, param_ready_d;

    logic [IW-1:0]         inv_clamp;
    logic [AW-1:0]         acc_init;
    logic                  last_col, last_row;

    // Integer part of an accumulator, clamped to the last valid source index.
    function automatic logic [ADDR_BITS-1:0] coord_of(input logic [AW-1:0] acc, input int lim);
        logic [AW-1:0] whole;
        whole = acc >> FRAC_BITS;
        if (whole > AW'(lim - 1))
            whole = AW'(lim - 1);
        return ADDR_BITS'(whole);
    endfunction

    // Saturating accumulate so extreme scales never wrap back to the top-left.
    function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a, input logic [IW-1:0] b);
        logic [AW:0] sum;
        sum = {1'b0, a} + (AW+1)'(b);
        return sum[AW] ? '1 : sum[AW-1:0];
    endfunction

    // Below 1.0 the walk would revisit source pixels; upscaling is not supported.
    assign inv_clamp = (inv_q < ONE_I) ? ONE_I : inv_q;

`ifdef SCALE_CENTER_SAMPLE_EN
    assign acc_init = AW'(inv_clamp >> 1);
`else
    assign acc_init = '0;
`endif

    assign last_col = (dst_x_q == width_q  - COORD_BITS'(1));
    assign last_row = (dst_y_q == height_q - COORD_BITS'(1));

    always_comb begin
        state_d    = state_q;
        inv_d      = inv_q;
        width_d    = width_q;
        height_d   = height_q;
        dst_x_d    = dst_x_q;
        dst_y_d    = dst_y_q;
        x_acc_d    = x_acc_q;
        y_acc_d    = y_acc_q;
        row_base_d = row_base_q;

        case (state_q)
            S_Idle: begin
                if (bus.param_valid) begin
                    inv_d    = bus.inv_scale;
                    width_d  = bus.new_width;
                    height_d = bus.new_height;
                    state_d  = S_Load;
                end
            end
            S_Load: begin
                inv_d   = inv_clamp;
                dst_x_d = '0;
                dst_y_d = '0;
                x_acc_d = acc_init;
                y_acc_d = acc_init;
                state_d = (width_q == '0 || height_q == '0) ? S_Done : S_RowCalc;
            end
            S_RowCalc: begin
                row_base_d = coord_of(y_acc_q, SRC_HEIGHT) * ADDR_BITS'(SRC_WIDTH);
                state_d    = S_Emit;
            end
            S_Emit: begin
                if (bus.addr_ready) begin
                    if (last_col) begin
                        dst_x_d = '0;
                        x_acc_d = acc_init;
                        if (last_row) begin
                            state_d = S_Done;
                        end else begin
                            dst_y_d = dst_y_q + COORD_BITS'(1);
                            y_acc_d = sat_add(y_acc_q, inv_q);
                            state_d = S_RowCalc;
                        end
                    end else begin
                        dst_x_d = dst_x_q + COORD_BITS'(1);
                        x_acc_d = sat_add(x_acc_q, inv_q);
                    end
                end
            end
            S_Done:  state_d = S_Idle;
            default: state_d = S_Idle;
        endcase

        // Outputs are registered from next-state values so they line up with state_q.
        src_addr_d    = row_base_d + coord_of(x_acc_d, SRC_WIDTH);
        addr_valid_d  = (state_d == S_Emit);
        last_d        = (state_d == S_Emit) && (dst_x_d == width_d - COORD_BITS'(1))
                        && (dst_y_d == height_d - COORD_BITS'(1));
        busy_d        = (state_d != S_Idle);
        done_d        = (state_d == S_Done);
        param_ready_d = (state_d == S_Idle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_Idle;
            inv_q         <= '0;
            width_q       <= '0;
            height_q      <= '0;
            dst_x_q       <= '0;
            dst_y_q       <= '0;
            x_acc_q       <= '0;
            y_acc_q       <= '0;
            row_base_q    <= '0;
            src_addr_q    <= '0;
            addr_valid_q  <= 1'b0;
            last_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            param_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            inv_q         <= inv_d;
            width_q       <= width_d;
            height_q      <= height_d;
            dst_x_q       <= dst_x_d;
            dst_y_q       <= dst_y_d;
            x_acc_q       <= x_acc_d;
            y_acc_q       <= y_acc_d;
            row_base_q    <= row_base_d;
            src_addr_q    <= src_addr_d;
            addr_valid_q  <= addr_valid_d;
            last_q        <= last_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            param_ready_q <= param_ready_d;
        end
    end

    assign bus.param_ready = param_ready_q;
    assign bus.addr_valid  = addr_valid_q;
    assign bus.src_addr    = src_addr_q;
    assign bus.dst_x       = dst_x_q;
    assign bus.dst_y       = dst_y_q;
    assign bus.last_pixel  = last_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_scaled_addr_gen.sv
// Directed bench for scaled_addr_gen: expected beats come from an arithmetic model into a queue.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: addr_ready is driven low for selected beats to exercise stalls.
module tb_scaled_addr_gen;
    localparam int SRC_WIDTH  = 320;
    localparam int SRC_HEIGHT = 240;
    localparam int COORD_BITS = 10;
    localparam int FRAC_BITS  = 16;
    localparam int ADDR_BITS  = 17;

    typedef struct {
        int addr;
        int x;
        int y;
        int last;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    beat_t sb[$];

    always #5 clk = ~clk;

    scaled_addr_gen_if #(.COORD_BITS(COORD_BITS), .FRAC_BITS(FRAC_BITS), .ADDR_BITS(ADDR_BITS)) bus();

    scaled_addr_gen #(
        .SRC_WIDTH (SRC_WIDTH),
        .SRC_HEIGHT(SRC_HEIGHT),
        .COORD_BITS(COORD_BITS),
        .FRAC_BITS (FRAC_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Source coordinate for scaled index idx: floor(start + idx*inv), clamped to the frame.
    function automatic int src_coord(input longint inv, input int idx, input int lim);
        longint acc;
`ifdef SCALE_CENTER_SAMPLE_EN
        acc = inv / 2;
`else
        acc = 0;
`endif
        acc = (acc + inv * longint'(idx)) / 65536;
        if (acc > longint'(lim - 1))
            acc = longint'(lim - 1);
        return int'(acc);
    endfunction

    task automatic run_scale(input int inv, input int w, input int h,
                             input int stall_beat, input int stall_len, input bit pulse,
                             input string name);
        longint ic;
        int c, beat, last_hs, first_c, bubbles, stall_left, done_c;
        beat_t e;

        ic = (inv < 65536) ? 64'd65536 : longint'(inv);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                e.addr = src_coord(ic, y, SRC_HEIGHT) * SRC_WIDTH + src_coord(ic, x, SRC_WIDTH);
                e.x    = x;
                e.y    = y;
                e.last = (x == w - 1 && y == h - 1) ? 1 : 0;
                sb.push_back(e);
            end
        end

        check({name, " param_ready idle"}, 32'(bus.param_ready), 32'd1);
        bus.param_valid = 1'b1;
        bus.inv_scale   = 26'(inv);
        bus.new_width   = 10'(w);
        bus.new_height  = 10'(h);
        bus.addr_ready  = 1'b1;
        tick();
        bus.param_valid = 1'b0;

        c = 1; beat = 0; last_hs = -1; first_c = -1; bubbles = 0; done_c = -1;
        stall_left = stall_len;
        while (c < 3000) begin
            bus.param_valid = 1'b0;
            if (pulse && c == 2) begin
                check({name, " busy during scale"}, 32'(bus.busy), 32'd1);
                bus.param_valid = 1'b1;
                bus.inv_scale   = 26'h3ffffff;
                bus.new_width   = 10'd1;
                bus.new_height  = 10'd1;
            end
            if (bus.done) begin
                done_c = c;
                break;
            end
            if (bus.addr_valid) begin
                if (first_c < 0) first_c = c;
                if (sb.size() == 0) begin
                    check({name, " unexpected extra beat"}, 32'd1, 32'd0);
                    bus.addr_ready = 1'b1;
                end else if (beat == stall_beat && stall_left > 0) begin
                    bus.addr_ready = 1'b0;
                    check({name, " stall src_addr"}, 32'(bus.src_addr), 32'(sb[0].addr));
                    check({name, " stall dst_x"},    32'(bus.dst_x),    32'(sb[0].x));
                    check({name, " stall dst_y"},    32'(bus.dst_y),    32'(sb[0].y));
                    stall_left--;
                end else begin
                    bus.addr_ready = 1'b1;
                    e = sb.pop_front();
                    check({name, " src_addr"},   32'(bus.src_addr),   32'(e.addr));
                    check({name, " dst_x"},      32'(bus.dst_x),      32'(e.x));
                    check({name, " dst_y"},      32'(bus.dst_y),      32'(e.y));
                    check({name, " last_pixel"}, 32'(bus.last_pixel), 32'(e.last));
                    beat++;
                    last_hs = c;
                end
            end else begin
                bus.addr_ready = 1'b1;
                if (first_c >= 0) bubbles++;
            end
            tick();
            c++;
        end
        bus.param_valid = 1'b0;

        check({name, " done within budget"}, 32'(done_c >= 0), 32'd1);
        check({name, " beats delivered"}, 32'(beat), 32'(w * h));
        check({name, " scoreboard drained"}, 32'(sb.size()), 32'd0);
        sb.delete();
        if (w * h > 0) begin
            check({name, " first valid latency"}, 32'(first_c), 32'd3);
            check({name, " done after last beat"}, 32'(done_c), 32'(last_hs + 1));
            check({name, " row bubbles"}, 32'(bubbles), 32'(h - 1));
        end else begin
            check({name, " no valid for empty"}, 32'(first_c), 32'hffffffff);
            check({name, " empty done latency"}, 32'(done_c), 32'd2);
        end
        tick();
        check({name, " done one cycle"}, 32'(bus.done), 32'd0);
        check({name, " param_ready back"}, 32'(bus.param_ready), 32'd1);
        check({name, " busy cleared"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int  n;
        bit  found, done_seen;

        reset           = 1'b1;
        bus.param_valid = 1'b0;
        bus.inv_scale   = '0;
        bus.new_width   = '0;
        bus.new_height  = '0;
        bus.addr_ready  = 1'b1;
        tick();
        tick();
        check("rst param_ready", 32'(bus.param_ready), 32'd1);
        check("rst addr_valid",  32'(bus.addr_valid),  32'd0);
        check("rst last_pixel",  32'(bus.last_pixel),  32'd0);
        check("rst busy",        32'(bus.busy),        32'd0);
        check("rst done",        32'(bus.done),        32'd0);
        check("rst src_addr",    32'(bus.src_addr),    32'd0);
        check("rst dst_x",       32'(bus.dst_x),       32'd0);
        check("rst dst_y",       32'(bus.dst_y),       32'd0);
        reset = 1'b0;
        tick();

        run_scale(32'h010000, 4,   2, -1, 0, 1'b0, "unity");
        run_scale(32'h014000, 4,   1, -1, 0, 1'b0, "frac125");
        run_scale(32'h020000, 2,   2, -1, 0, 1'b0, "half");
        run_scale(32'h008000, 2,   2, -1, 0, 1'b0, "clamp_min");
        run_scale(32'h010000, 4,   2,  2, 3, 1'b1, "stall");
        run_scale(32'h020000, 0,   5, -1, 0, 1'b0, "zero_w");
        run_scale(32'h020000, 200, 1, -1, 0, 1'b0, "edge_clamp");

        // Abort a scale partway through row 1 with a synchronous reset.
        bus.param_valid = 1'b1;
        bus.inv_scale   = 26'h010000;
        bus.new_width   = 10'd4;
        bus.new_height  = 10'd3;
        bus.addr_ready  = 1'b1;
        tick();
        bus.param_valid = 1'b0;
        found = 1'b0;
        n = 0;
        while (n < 50 && !found) begin
            if (bus.addr_valid && bus.dst_y == 10'd1 && bus.dst_x == 10'd1) found = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        check("mid reset reached row 1", 32'(found), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid reset addr_valid",  32'(bus.addr_valid),  32'd0);
        check("mid reset busy",        32'(bus.busy),        32'd0);
        check("mid reset param_ready", 32'(bus.param_ready), 32'd1);
        check("mid reset done",        32'(bus.done),        32'd0);
        check("mid reset dst_x",       32'(bus.dst_x),       32'd0);
        check("mid reset dst_y",       32'(bus.dst_y),       32'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.done || bus.addr_valid) done_seen = 1'b1;
        end
        check("mid reset stays quiet", 32'(done_seen), 32'd0);

        run_scale(32'h010000, 3, 2, -1, 0, 1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
